dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store bus between the control unit/datapath and the data-memory controller.
// Handshake: a request is taken only when the controller is idle; while stall is high the
// requester must hold the PC and register file, and readdata is valid in the first cycle stall drops after a load.
interface dmem_if #(
  parameter int N = 16
);
  logic         memread;
  logic         memwrite;
  logic [N-1:0] addr;
  logic [N-1:0] writedata;
  logic [N-1:0] readdata;
  logic         stall;
  logic         err;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall, err
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: single-cycle stores, RD_LAT-cycle loads with stall,
// and a sticky error flag for read/write conflicts and odd byte addresses.
module dmem_ctrl #(
  parameter int N      = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [N-1:0]   mem_q [DEPTH];

  logic [IW-1:0]  req_idx;
  logic           stall_c;
  logic           we_c;
  logic           unused_addr_hi;

  // Word index from the byte address; upper bits are dropped so accesses wrap.
  assign req_idx        = bus.addr[IW:1];
  assign unused_addr_hi = ^bus.addr[N-1:IW+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    we_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.memread) begin
          stall_c = 1'b1;
          idx_d   = req_idx;
          if (bus.memwrite || bus.addr[0]) err_d = 1'b1;
          if (RD_LAT == 1) begin
            rdata_d = mem_q[req_idx];
            state_d = DONE;
          end else begin
            cnt_d   = 3'(RD_LAT - 1);
            state_d = BUSY;
          end
        end else if (bus.memwrite) begin
          we_c = 1'b1;
          if (bus.addr[0]) err_d = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_q[idx_q];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately outside the reset domain so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (we_c && !reset) mem_q[req_idx] <= bus.writedata;
  end

  assign bus.stall    = stall_c & ~reset;
  assign bus.readdata = rdata_q;
  assign bus.err      = err_q;
  assign dbg_state    = state_q;
endmodule
